uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Serial receiver that consumes the TX_OUT line produced by the UART transmitter and rebuilds each frame.
- Frame format: start bit, data bits LSB-first, optional parity bit, stop bit.
- Oversamples the line with a programmable prescale, majority-votes each bit, checks parity and stop bit, and delivers a parallel word with a single-cycle valid pulse.
- Sits at the serial-to-parallel boundary, feeding the system control/register path.

Parameters:
- data_width, 8, data bits per frame
- prescale_width, 6, width of the Prescale input

Ports:
- CLK  input  1  oversampling clock, Prescale × baud rate
- RST  input  1  asynchronous active-low reset
- RX_IN  input  1  serial line, idles high
- Prescale  input  prescale_width  oversampling ratio; 8, 16 or 32
- PAR_EN  input  1  1 = frame carries a parity bit
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- P_DATA  output  data_width  received word
- Data_Valid  output  1  one-cycle pulse, P_DATA is valid
- PAR_ERR  output  1  one-cycle pulse, parity mismatch
- STP_ERR  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Reset values:
  - P_DATA = 0; Data_Valid, PAR_ERR and STP_ERR = 0.
  - FSM in IDLE; edge counter and bit counter = 0.
- Unsupported Prescale values are treated as 8.
- PAR_EN, PAR_TYP and Prescale are sampled when leaving IDLE and held for the whole frame. Mid-frame changes have no effect.
- Edge counter:
  - Counts 0..Prescale-1 within each bit period.
  - The bit counter increments when the edge counter wraps.
- Sampling:
  - Three samples per bit, taken at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1.
  - The bit value is the 2-of-3 majority.
  - The voted bit is available when the edge counter reaches Prescale/2+2.
- States:
  - IDLE: RX_IN==0 moves to START. The cycle RX_IN is first seen low is t0 and counts as edge 0 of the start bit.
  - START: if the voted start bit is 1 (glitch), return to IDLE at edge Prescale-1 with no outputs. Otherwise go to DATA at the end of the bit.
  - DATA: shift the voted bits in LSB-first for data_width bits. Then go to PARITY if PAR_EN, else to STOP.
  - PARITY: compare the voted bit with the computed parity over the shift register. Latch the mismatch internally.
  - STOP: voted stop bit 0 means a stop error.
- End of frame:
  - The last stop-bit edge is at t0 + N×Prescale − 1, where N = data_width+2+PAR_EN.
  - At t0 + N×Prescale, exactly one of these happens:
    - Data_Valid=1 and P_DATA updated, if there is no error; or
    - PAR_ERR and/or STP_ERR = 1 for one cycle, with P_DATA not updated and Data_Valid staying 0.
- After the stop bit:
  - If RX_IN==0 on the cycle following the stop bit's last edge, that cycle is t0 of the next frame and the FSM goes directly to START. No idle cycle is required.
  - Otherwise the FSM returns to IDLE.
- P_DATA holds its value between frames.
- Reset mid-frame: all state is cleared immediately and no pulse is emitted. A frame whose start bit was lost is ignored until the line returns high and falls again.

Optional Feature:
- Macro: UART_RX_SYNC_EN
- Defined:
  - RX_IN passes through a two-flop synchronizer, reset to 1, before the FSM.
  - All timing referenced to t0 shifts by +2 cycles relative to the pin.
- Undefined:
  - RX_IN feeds the FSM directly. The integrator guarantees the line is already synchronous to CLK.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 → P_DATA=0xA5, Data_Valid high exactly at t0+80 for 1 cycle, PAR_ERR=STP_ERR=0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C with parity bit 0 → P_DATA=0x3C, Data_Valid at t0+176. Same frame with parity bit 1 → PAR_ERR pulse at t0+176, no Data_Valid, P_DATA unchanged.
- Prescale=32, PAR_EN=0, data 0x81 with stop bit forced 0 → STP_ERR pulse at t0+320, Data_Valid stays 0.
- Prescale=16, RX_IN low for 3 cycles then high → FSM returns to IDLE by t0+16 with no pulses. A single corrupted mid-bit sample inside a valid 0x5A frame still yields P_DATA=0x5A.
- Back-to-back frames 0x11 then 0xEE at Prescale=8 with no idle gap → two Data_Valid pulses exactly 80 cycles apart, with the correct data each time.
- RST asserted at t0+40 of a frame → all outputs 0 immediately; no pulse follows; the next clean frame 0x77 is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Brief    : Oversampling UART receiver with 2-of-3 majority vote, optional
//            parity and stop-bit checking. Define UART_RX_SYNC_EN to add a
//            two-flop input synchronizer on RX_IN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   output logic [DATA_WIDTH-1:0]     P_DATA,
   output logic                      Data_Valid,
   output logic                      PAR_ERR,
   output logic                      STP_ERR
);

   localparam int c_BIT_CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT = c_BIT_CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   logic w_rx;
   logic w_rx_known;

`ifdef UART_RX_SYNC_EN
   logic [1:0] r_sync;
   logic [1:0] r_fill;

   // r_fill marks when the synchronizer holds real line data rather than its reset value
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sync <= 2'b11;
         r_fill <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], RX_IN};
         r_fill <= {r_fill[0], 1'b1};
      end
   end

   assign w_rx       = r_sync[1];
   assign w_rx_known = r_fill[1];
`else
   assign w_rx       = RX_IN;
   assign w_rx_known = 1'b1;
`endif

   state_t                    r_state;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
   logic [c_BIT_CNT_W-1:0]    r_bit_cnt;
   logic [DATA_WIDTH-1:0]     r_shift;
   logic [2:0]                r_samp;
   logic                      r_par_en;
   logic                      r_par_typ;
   logic                      r_par_bad;
   logic                      r_stp_bad;
   logic                      r_done;
   logic                      r_armed;

   logic [PRESCALE_WIDTH-1:0] w_prescale_dec;
   logic [PRESCALE_WIDTH-1:0] w_half;
   logic [PRESCALE_WIDTH-1:0] w_last;
   logic                      w_edge_last;
   logic                      w_voted;

   always_comb begin
      w_prescale_dec = PRESCALE_WIDTH'(8);
      if (Prescale == PRESCALE_WIDTH'(16) || Prescale == PRESCALE_WIDTH'(32))
         w_prescale_dec = Prescale;
   end

   assign w_half      = r_prescale >> 1;
   assign w_last      = r_prescale - PRESCALE_WIDTH'(1);
   assign w_edge_last = (r_edge_cnt == w_last);
   assign w_voted     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_prescale <= PRESCALE_WIDTH'(8);
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_samp     <= '0;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
         r_par_bad  <= 1'b0;
         r_stp_bad  <= 1'b0;
         r_done     <= 1'b0;
         r_armed    <= 1'b0;
         P_DATA     <= '0;
         Data_Valid <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
         r_done     <= 1'b0;

         // Frame verdict goes out the cycle after the last stop-bit edge
         if (r_done) begin
            if (!r_par_bad && !r_stp_bad) begin
               Data_Valid <= 1'b1;
               P_DATA     <= r_shift;
            end
            PAR_ERR <= r_par_bad;
            STP_ERR <= r_stp_bad;
         end

         // A start can only be taken after the line has been seen idle high
         if (w_rx && w_rx_known)
            r_armed <= 1'b1;

         if (r_state != S_IDLE) begin
            r_edge_cnt <= w_edge_last ? '0 : r_edge_cnt + PRESCALE_WIDTH'(1);
            if (r_edge_cnt == w_half - PRESCALE_WIDTH'(1)) r_samp[0] <= w_rx;
            if (r_edge_cnt == w_half)                      r_samp[1] <= w_rx;
            if (r_edge_cnt == w_half + PRESCALE_WIDTH'(1)) r_samp[2] <= w_rx;
         end

         case (r_state)
            S_IDLE: begin
               if (!w_rx && r_armed) begin
                  r_state    <= S_START;
                  r_edge_cnt <= PRESCALE_WIDTH'(1);
                  r_bit_cnt  <= '0;
                  r_prescale <= w_prescale_dec;
                  r_par_en   <= PAR_EN;
                  r_par_typ  <= PAR_TYP;
                  r_par_bad  <= 1'b0;
                  r_stp_bad  <= 1'b0;
               end
            end
            S_START: begin
               if (w_edge_last)
                  r_state <= w_voted ? S_IDLE : S_DATA;
            end
            S_DATA: begin
               if (w_edge_last) begin
                  r_shift <= {w_voted, r_shift[DATA_WIDTH-1:1]};
                  if (r_bit_cnt == c_LAST_BIT) begin
                     r_bit_cnt <= '0;
                     r_state   <= r_par_en ? S_PARITY : S_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + c_BIT_CNT_W'(1);
                  end
               end
            end
            S_PARITY: begin
               if (w_edge_last) begin
                  r_par_bad <= (w_voted != ((^r_shift) ^ r_par_typ));
                  r_state   <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_edge_last) begin
                  r_stp_bad <= ~w_voted;
                  r_done    <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Brief    : Directed frames into uart_rx_core, checked every cycle against a
//            frame-level expectation queue plus literal timing/data checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

`ifdef UART_RX_SYNC_EN
   localparam int c_LAT = 2;
`else
   localparam int c_LAT = 0;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_ERR;
   logic       STP_ERR;

   uart_rx_core dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .Prescale   (Prescale),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_ERR    (PAR_ERR),
      .STP_ERR    (STP_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         cyc;
      logic       dv;
      logic       pe;
      logic       se;
      logic [7:0] d;
   } ev_t;

   ev_t        evq[$];
   ev_t        plog[$];
   ev_t        obs;
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] m_pdata = 8'h00;
   logic       ex_dv, ex_pe, ex_se;

   always @(posedge CLK) cyc <= cyc + 1;

   // Per-cycle compare against the frame-level expectation queue
   always @(negedge CLK) begin
      if (!RST) begin
         m_pdata = 8'h00;
         evq.delete();
      end
      ex_dv = 1'b0;
      ex_pe = 1'b0;
      ex_se = 1'b0;
      if (evq.size() > 0 && evq[0].cyc < cyc) begin
         miscompares++;
         $display("FAIL stale_expect: cycle %0d passed expected event at %0d", cyc, evq[0].cyc);
         void'(evq.pop_front());
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
         ex_dv = evq[0].dv;
         ex_pe = evq[0].pe;
         ex_se = evq[0].se;
         if (evq[0].dv) m_pdata = evq[0].d;
         void'(evq.pop_front());
      end
      vectors++;
      if ({Data_Valid, PAR_ERR, STP_ERR} !== {ex_dv, ex_pe, ex_se} || P_DATA !== m_pdata) begin
         miscompares++;
         $display("FAIL cycle_%0d outputs: got dv/pe/se=%b%b%b P_DATA=%h, want dv/pe/se=%b%b%b P_DATA=%h",
                  cyc, Data_Valid, PAR_ERR, STP_ERR, P_DATA, ex_dv, ex_pe, ex_se, m_pdata);
      end
      if (Data_Valid || PAR_ERR || STP_ERR) begin
         obs.cyc = cyc;
         obs.dv  = Data_Valid;
         obs.pe  = PAR_ERR;
         obs.se  = STP_ERR;
         obs.d   = P_DATA;
         plog.push_back(obs);
      end
   end

   task automatic chk(input string nm, input int got, input int want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   task automatic chk_pulse(input string nm, input int idx, input int exp_cyc,
                            input logic [2:0] kind, input logic [7:0] d);
      vectors++;
      if (idx >= plog.size()) begin
         miscompares++;
         $display("FAIL %s: pulse %0d missing, want kind %b at cycle %0d", nm, idx, kind, exp_cyc);
      end else if (plog[idx].cyc != exp_cyc ||
                   {plog[idx].dv, plog[idx].pe, plog[idx].se} !== kind ||
                   (kind[2] && plog[idx].d !== d)) begin
         miscompares++;
         $display("FAIL %s: got kind %b at cycle %0d data %h, want kind %b at cycle %0d data %h",
                  nm, {plog[idx].dv, plog[idx].pe, plog[idx].se}, plog[idx].cyc, plog[idx].d,
                  kind, exp_cyc, d);
      end
   endtask

   task automatic drive_level(input logic lv, input int n, output int t_first);
      t_first = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
         if (i == 0) t_first = cyc + 1;
         RX_IN = lv;
      end
   endtask

   // Drives one frame and queues the outcome the receiver must report
   task automatic send_frame(input logic [7:0] data, input int p, input logic pen, input logic ptyp,
                             input logic par_flip, input logic stop_lvl, input int corrupt_bit,
                             input logic disturb, output int t0);
      logic lv[$];
      int   pe;
      ev_t  ev;
      logic par_req;
      pe = (p == 16 || p == 32) ? p : 8;
      par_req = (^data) ^ ptyp;
      lv.push_back(1'b0);
      for (int i = 0; i < 8; i++) lv.push_back(data[i]);
      if (pen) lv.push_back(par_req ^ par_flip);
      lv.push_back(stop_lvl);
      t0 = 0;
      for (int b = 0; b < lv.size(); b++) begin
         for (int e = 0; e < pe; e++) begin
            @(posedge CLK);
            #1;
            if (b == 0 && e == 0) begin
               t0       = cyc + 1;
               Prescale = 6'(p);
               PAR_EN   = pen;
               PAR_TYP  = ptyp;
            end
            if (disturb && b == 2 && e == 0) begin
               Prescale = 6'd8;
               PAR_EN   = ~pen;
               PAR_TYP  = ~ptyp;
            end
            RX_IN = (b == corrupt_bit && e == pe / 2) ? ~lv[b] : lv[b];
         end
      end
      ev.cyc = t0 + lv.size() * pe + c_LAT;
      ev.pe  = pen && (lv[9] != par_req);
      ev.se  = !stop_lvl;
      ev.dv  = !ev.pe && !ev.se;
      ev.d   = data;
      evq.push_back(ev);
   endtask

   initial begin
      int t0, t1, tmp;
      RST      = 1'b0;
      RX_IN    = 1'b1;
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_pdata", P_DATA, 0);
      chk("reset_flags", {Data_Valid, PAR_ERR, STP_ERR}, 0);
      RST = 1'b1;
      drive_level(1'b1, 10, tmp);

      // Prescale 8, no parity
      plog.delete();
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, t0);
      drive_level(1'b1, 8, tmp);
      chk("a5_count", plog.size(), 1);
      chk_pulse("a5", 0, t0 + 80 + c_LAT, 3'b100, 8'hA5);

      // Prescale 16, even parity, correct then wrong parity bit
      plog.delete();
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, t0);
      drive_level(1'b1, 8, tmp);
      chk("3c_count", plog.size(), 1);
      chk_pulse("3c_even", 0, t0 + 176 + c_LAT, 3'b100, 8'h3C);
      plog.delete();
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, t0);
      drive_level(1'b1, 8, tmp);
      chk("3c_perr_count", plog.size(), 1);
      chk_pulse("3c_perr", 0, t0 + 176 + c_LAT, 3'b010, 8'h00);
      chk("3c_perr_hold", P_DATA, 8'h3C);

      // Odd parity at Prescale 8
      plog.delete();
      send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0, t0);
      drive_level(1'b1, 8, tmp);
      chk_pulse("3c_odd", 0, t0 + 88 + c_LAT, 3'b100, 8'h3C);

      // Prescale 32, stop bit forced low
      plog.delete();
      send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, t0);
      drive_level(1'b1, 8, tmp);
      chk("81_count", plog.size(), 1);
      chk_pulse("81_serr", 0, t0 + 320 + c_LAT, 3'b001, 8'h00);
      chk("81_hold", P_DATA, 8'h3C);

      // Unsupported Prescale behaves as 8
      plog.delete();
      send_frame(8'h96, 12, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, t0);
      drive_level(1'b1, 8, tmp);
      chk_pulse("96_pres12", 0, t0 + 80 + c_LAT, 3'b100, 8'h96);

      // Start glitch, then a frame with one bad sample and mid-frame config changes
      plog.delete();
      drive_level(1'b0, 3, t0);
      drive_level(1'b1, 13, tmp);
      send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1, t1);
      drive_level(1'b1, 8, tmp);
      chk("5a_count", plog.size(), 1);
      chk_pulse("5a", 0, t0 + 16 + 160 + c_LAT, 3'b100, 8'h5A);

      // Back-to-back frames, no idle gap
      plog.delete();
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, t0);
      send_frame(8'hEE, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, t1);
      drive_level(1'b1, 8, tmp);
      chk("b2b_count", plog.size(), 2);
      chk_pulse("b2b_11", 0, t0 + 80 + c_LAT, 3'b100, 8'h11);
      chk_pulse("b2b_ee", 1, t0 + 160 + c_LAT, 3'b100, 8'hEE);

      // Reset in the middle of a frame with the line held low through release
      plog.delete();
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      drive_level(1'b0, 40, t0);
      @(posedge CLK);
      #1 RST = 1'b0;
      #1;
      chk("midrst_pdata", P_DATA, 0);
      chk("midrst_flags", {Data_Valid, PAR_ERR, STP_ERR}, 0);
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      drive_level(1'b0, 6, tmp);
      drive_level(1'b1, 30, tmp);
      send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, t1);
      drive_level(1'b1, 8, tmp);
      chk("77_count", plog.size(), 1);
      chk_pulse("77", 0, t1 + 80 + c_LAT, 3'b100, 8'h77);

      drive_level(1'b1, 4, tmp);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
